// File: rtl/bitwise_serial_unit.sv
// bitwise_serial_unit
// Bit-serial OR / AND / NOT engine. Captures two operands on an accepted
// start strobe and walks them LSB-first, one bit per clock. Each bit's
// results appear on the serial outputs during its cycle. The bit is also
// shifted into per-operation result registers, which are published as
// parallel words when the last bit has been processed.
module bitwise_serial_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             busy,
    output logic             ser_valid,
    output logic             ser_or,
    output logic             ser_and,
    output logic             ser_not,
    output logic [WIDTH-1:0] A_or_B,
    output logic [WIDTH-1:0] A_and_B,
    output logic [WIDTH-1:0] not_A,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] or_sr;
    logic [WIDTH-1:0] and_sr;
    logic [WIDTH-1:0] not_sr;
    logic             accept;
    logic             last_bit;
    logic             shifting;

    // The operand registers are shifted right every SHIFT cycle. Bit 0 is
    // therefore always the bit currently indexed by cnt. This avoids a
    // variable-index mux on the operands.
    assign shifting  = (state == ST_SHIFT);
    assign ready     = (state == ST_IDLE) || (state == ST_DONE);
    assign busy      = shifting;
    assign ser_valid = shifting;
    assign done      = (state == ST_DONE);
    assign accept    = ready && start;
    assign last_bit  = shifting && (cnt == LAST_BIT);

    assign ser_or  = shifting & (a_reg[0] | b_reg[0]);
    assign ser_and = shifting & (a_reg[0] & b_reg[0]);
    assign ser_not = shifting & ~a_reg[0];

    // Next-state selection; DONE is always a single cycle and may chain
    // straight into a new operation when start is present.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_next = ST_DONE;
            ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Operand capture and per-cycle operand shift / bit counter. A start
    // that is not accepted (while busy) leaves the captured operands alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            cnt   <= '0;
        end else if (shifting) begin
            a_reg <= a_reg >> 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    // Result shift registers: each serial bit enters at the MSB. After
    // WIDTH shifts the first (LSB) bit has arrived at position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            or_sr  <= '0;
            and_sr <= '0;
            not_sr <= '0;
        end else if (shifting) begin
            or_sr  <= {ser_or,  or_sr[WIDTH-1:1]};
            and_sr <= {ser_and, and_sr[WIDTH-1:1]};
            not_sr <= {ser_not, not_sr[WIDTH-1:1]};
        end
    end

    // Parallel results update only on completion. The final bit is merged
    // in here directly, so the words never expose a partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            A_or_B  <= '0;
            A_and_B <= '0;
            not_A   <= '0;
        end else if (last_bit) begin
            A_or_B  <= {ser_or,  or_sr[WIDTH-1:1]};
            A_and_B <= {ser_and, and_sr[WIDTH-1:1]};
            not_A   <= {ser_not, not_sr[WIDTH-1:1]};
        end
    end

endmodule

// File: tb/tb_bitwise_serial_unit.sv
// Testbench for bitwise_serial_unit: a WIDTH=4 instance driven from a
// vector table plus hand-written multi-cycle sequences, and a WIDTH=8
// instance for the wide build.
module tb_bitwise_serial_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a_in, b_in;
    logic       ready, busy, ser_valid, ser_or, ser_and, ser_not, done;
    logic [3:0] a_or_b, a_and_b, not_a;

    logic       start8;
    logic [7:0] a8, b8;
    logic       ready8, busy8, ser_valid8, ser_or8, ser_and8, ser_not8, done8;
    logic [7:0] a_or_b8, a_and_b8, not_a8;

    int errors = 0;
    int checks = 0;

    logic [3:0] prev_or = 4'h0, prev_and = 4'h0, prev_not = 4'h0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_or;
        logic [3:0] exp_and;
        logic [3:0] exp_not;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    bitwise_serial_unit #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
        .ready(ready), .busy(busy), .ser_valid(ser_valid),
        .ser_or(ser_or), .ser_and(ser_and), .ser_not(ser_not),
        .A_or_B(a_or_b), .A_and_B(a_and_b), .not_A(not_a), .done(done)
    );

    bitwise_serial_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
        .ready(ready8), .busy(busy8), .ser_valid(ser_valid8),
        .ser_or(ser_or8), .ser_and(ser_and8), .ser_not(ser_not8),
        .A_or_B(a_or_b8), .A_and_B(a_and_b8), .not_A(not_a8), .done(done8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Raise start with the given operands for the capture edge; afterwards
    // the DUT sits in SHIFT cycle 0 with start still high.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
    endtask

    // Walk SHIFT cycles 0..3 checking the serial stream and that the
    // parallel words still hold the previous results, then check the DONE
    // cycle. start is dropped from cycle 'hold' onward. Ends in DONE.
    task automatic shiftPhase(input logic [3:0] eo, input logic [3:0] ea,
                              input logic [3:0] en, input int hold);
        for (int i = 0; i < 4; i++) begin
            if (i >= hold) start = 1'b0;
            checkOutput($sformatf("busy[%0d]", i), {7'b0, busy}, 8'h01);
            checkOutput($sformatf("ser_valid[%0d]", i), {7'b0, ser_valid}, 8'h01);
            checkOutput($sformatf("ser_or[%0d]", i), {7'b0, ser_or}, {7'b0, eo[i]});
            checkOutput($sformatf("ser_and[%0d]", i), {7'b0, ser_and}, {7'b0, ea[i]});
            checkOutput($sformatf("ser_not[%0d]", i), {7'b0, ser_not}, {7'b0, en[i]});
            checkOutput($sformatf("done_early[%0d]", i), {7'b0, done}, 8'h00);
            checkOutput($sformatf("hold_or[%0d]", i), {4'b0, a_or_b}, {4'b0, prev_or});
            checkOutput($sformatf("hold_and[%0d]", i), {4'b0, a_and_b}, {4'b0, prev_and});
            checkOutput($sformatf("hold_not[%0d]", i), {4'b0, not_a}, {4'b0, prev_not});
            step();
        end
        checkOutput("done", {7'b0, done}, 8'h01);
        checkOutput("ready_done", {7'b0, ready}, 8'h01);
        checkOutput("ser_valid_done", {7'b0, ser_valid}, 8'h00);
        checkOutput("A_or_B", {4'b0, a_or_b}, {4'b0, eo});
        checkOutput("A_and_B", {4'b0, a_and_b}, {4'b0, ea});
        checkOutput("not_A", {4'b0, not_a}, {4'b0, en});
        prev_or  = eo;
        prev_and = ea;
        prev_not = en;
    endtask

    // One cycle after DONE with no start: back in IDLE, results held.
    task automatic checkIdle(input string tag);
        step();
        checkOutput({tag, "_done_clr"}, {7'b0, done}, 8'h00);
        checkOutput({tag, "_busy"}, {7'b0, busy}, 8'h00);
        checkOutput({tag, "_ready"}, {7'b0, ready}, 8'h01);
        checkOutput({tag, "_keep_or"}, {4'b0, a_or_b}, {4'b0, prev_or});
        checkOutput({tag, "_keep_not"}, {4'b0, not_a}, {4'b0, prev_not});
    endtask

    initial begin
        int         n;
        logic [7:0] g_or, g_and, g_not;

        vecs[0] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b0101};
        vecs[1] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1110};
        vecs[2] = '{4'b1100, 4'b1010, 4'b1110, 4'b1000, 4'b0011};
        vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
        vecs[4] = '{4'b1111, 4'b0110, 4'b1111, 4'b0110, 4'b0000};

        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        step();
        step();
        checkOutput("rst_ready", {7'b0, ready}, 8'h01);
        checkOutput("rst_busy", {7'b0, busy}, 8'h00);
        checkOutput("rst_done", {7'b0, done}, 8'h00);
        checkOutput("rst_ser_valid", {7'b0, ser_valid}, 8'h00);
        checkOutput("rst_ser_bits", {5'b0, ser_or, ser_and, ser_not}, 8'h00);
        checkOutput("rst_or", {4'b0, a_or_b}, 8'h00);
        checkOutput("rst_and", {4'b0, a_and_b}, 8'h00);
        checkOutput("rst_not", {4'b0, not_a}, 8'h00);
        checkOutput("rst_ready8", {7'b0, ready8}, 8'h01);
        rst = 1'b0;
        step();

        $display("[TB] table vectors");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].a, vecs[v].b);
            shiftPhase(vecs[v].exp_or, vecs[v].exp_and, vecs[v].exp_not, 0);
            checkIdle($sformatf("vec%0d", v));
        end

        $display("[TB] start held during SHIFT is ignored");
        applyStimulus(4'b0001, 4'b0001);
        a_in = 4'b1111;
        b_in = 4'b1111;
        shiftPhase(4'b0001, 4'b0001, 4'b1110, 3);
        checkIdle("ignore");

        $display("[TB] back-to-back via DONE cycle");
        applyStimulus(4'b1010, 4'b0101);
        shiftPhase(4'b1111, 4'b0000, 4'b0101, 0);
        a_in  = 4'b1111;
        b_in  = 4'b0000;
        start = 1'b1;
        step();
        shiftPhase(4'b1111, 4'b0000, 4'b0000, 0);
        checkIdle("b2b");

        $display("[TB] reset during SHIFT");
        applyStimulus(4'b0110, 4'b0011);
        start = 1'b0;
        step();
        step();
        checkOutput("mid_busy", {7'b0, busy}, 8'h01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("abort_ready", {7'b0, ready}, 8'h01);
        checkOutput("abort_busy", {7'b0, busy}, 8'h00);
        checkOutput("abort_ser_valid", {7'b0, ser_valid}, 8'h00);
        checkOutput("abort_done", {7'b0, done}, 8'h00);
        checkOutput("abort_or", {4'b0, a_or_b}, 8'h00);
        checkOutput("abort_and", {4'b0, a_and_b}, 8'h00);
        checkOutput("abort_not", {4'b0, not_a}, 8'h00);
        prev_or = 4'h0; prev_and = 4'h0; prev_not = 4'h0;
        step();
        checkOutput("abort_no_done", {7'b0, done}, 8'h00);
        applyStimulus(4'b0110, 4'b0011);
        shiftPhase(4'b0111, 4'b0010, 4'b1001, 0);
        checkIdle("after_abort");

        $display("[TB] WIDTH=8 build");
        a8 = 8'hF0;
        b8 = 8'h3C;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        g_or = '0; g_and = '0; g_not = '0;
        while (done8 !== 1'b1 && n < 20) begin
            if (n < 8) begin
                g_or[n]  = ser_or8;
                g_and[n] = ser_and8;
                g_not[n] = ser_not8;
            end
            n++;
            step();
        end
        checkOutput("w8_latency", 8'(n), 8'd8);
        checkOutput("w8_done", {7'b0, done8}, 8'h01);
        checkOutput("w8_ser_or", g_or, 8'hFC);
        checkOutput("w8_ser_and", g_and, 8'h30);
        checkOutput("w8_ser_not", g_not, 8'h0F);
        checkOutput("w8_or", a_or_b8, 8'hFC);
        checkOutput("w8_and", a_and_b8, 8'h30);
        checkOutput("w8_not", not_a8, 8'h0F);
        step();
        checkOutput("w8_done_clr", {7'b0, done8}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
